// File: rtl/fifo_sc_pack.sv
// Single-clock FIFO that packs RATIO narrow write pieces into one wide read word.
// Define FIFO_FWFT_EN for first-word-fall-through output; the default is standard read mode.
module fifo_sc_pack #(
  parameter int DIN_W    = 2,
  parameter int RATIO    = 2,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [DIN_W-1:0]          Data,
  input  logic                      WrEn,
  input  logic                      RdEn,
  output logic [DIN_W*RATIO-1:0]    Q,
  output logic                      Full,
  output logic                      Empty,
  output logic                      AlmostFull,
  output logic                      AlmostEmpty,
  output logic [$clog2(DEPTH):0]    Count,
  output logic                      Overflow,
  output logic                      Underflow
);

  localparam int QW = DIN_W * RATIO;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(RATIO);
  localparam int SW = (RATIO - 1) * DIN_W;

  localparam logic [PW-1:0] LAST_PIECE = PW'(RATIO - 1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C       = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C       = CW'(AE_LEVEL);

  logic [QW-1:0] r_mem [DEPTH];
  logic [SW-1:0] r_shift;
  logic [PW-1:0] r_piece_cnt;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [QW-1:0] r_q;
  logic          r_ovf;
  logic          r_udf;

  logic          w_full;
  logic          w_empty;
  logic          w_wr_acc;
  logic          w_complete;
  logic          w_rd_acc;
  logic          w_load;
  logic [QW-1:0] w_word;

  // Request/accept: a write is taken when WrEn & !Full, a read when RdEn & !Empty,
  // both judged on registered state at the start of the cycle; refused requests set the sticky flags.
  assign w_full     = (r_count == DEPTH_C);
  assign w_wr_acc   = WrEn & ~w_full;
  assign w_complete = w_wr_acc & (r_piece_cnt == LAST_PIECE);
  assign w_rd_acc   = RdEn & ~w_empty;
  assign w_word     = {Data, r_shift};

`ifdef FIFO_FWFT_EN
  logic r_q_valid;
  logic w_ram_avail;

  // Count includes the prefetched head, so RAM holds a word whenever Count exceeds the valid bit.
  assign w_ram_avail = (r_count != CW'(r_q_valid));
  assign w_empty     = ~r_q_valid;
  assign w_load      = w_ram_avail & (~r_q_valid | w_rd_acc);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_q_valid <= 1'b0;
    end else if (w_load) begin
      r_q_valid <= 1'b1;
    end else if (w_rd_acc) begin
      r_q_valid <= 1'b0;
    end
  end
`else
  assign w_empty = (r_count == '0);
  assign w_load  = w_rd_acc;
`endif

  always_ff @(posedge Clock) begin
    if (w_complete) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  // Partial pieces live only here; the piece counter reset is what discards them.
  always_ff @(posedge Clock) begin
    if (w_wr_acc && !w_complete) begin
      r_shift[r_piece_cnt*DIN_W +: DIN_W] <= Data;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_piece_cnt <= '0;
      r_wr_ptr    <= '0;
    end else if (w_wr_acc) begin
      r_piece_cnt <= w_complete ? '0 : r_piece_cnt + 1'b1;
      if (w_complete) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_rd_ptr <= '0;
      r_q      <= '0;
    end else if (w_load) begin
      r_rd_ptr <= r_rd_ptr + 1'b1;
      r_q      <= r_mem[r_rd_ptr];
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_count <= '0;
    end else begin
      case ({w_complete, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (WrEn && w_full) begin
        r_ovf <= 1'b1;
      end
      if (RdEn && w_empty) begin
        r_udf <= 1'b1;
      end
    end
  end

  assign Q           = r_q;
  assign Full        = w_full;
  assign Empty       = w_empty;
  assign AlmostFull  = (r_count >= AF_C);
  assign AlmostEmpty = (r_count <= AE_C);
  assign Count       = r_count;
  assign Overflow    = r_ovf;
  assign Underflow   = r_udf;

endmodule

// File: tb/tb_fifo_sc_pack.sv
// Bench for fifo_sc_pack: a 2x2 packing instance driven through a reference model and
// scoreboard, plus a 2x4 instance for the reset-mid-word case. Honours FIFO_FWFT_EN.
module tb_fifo_sc_pack;

  // ---------------- clock / reset ----------------
  logic       Clock = 1'b0;
  always #5 Clock = ~Clock;

  // instance A: DIN_W=2, RATIO=2, DEPTH=16
  logic       Reset = 1'b1;
  logic [1:0] Data  = '0;
  logic       WrEn  = 1'b0;
  logic       RdEn  = 1'b0;
  logic [3:0] Q;
  logic       Full, Empty, AlmostFull, AlmostEmpty, Overflow, Underflow;
  logic [4:0] Count;

  fifo_sc_pack #(.DIN_W(2), .RATIO(2), .DEPTH(16)) dut_a (
    .Clock(Clock), .Reset(Reset), .Data(Data), .WrEn(WrEn), .RdEn(RdEn),
    .Q(Q), .Full(Full), .Empty(Empty), .AlmostFull(AlmostFull),
    .AlmostEmpty(AlmostEmpty), .Count(Count), .Overflow(Overflow), .Underflow(Underflow)
  );

  // instance B: DIN_W=2, RATIO=4, DEPTH=4
  logic       b_reset = 1'b1;
  logic [1:0] b_data  = '0;
  logic       b_wr    = 1'b0;
  logic       b_rd    = 1'b0;
  logic [7:0] b_q;
  logic       b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
  logic [2:0] b_count;

  fifo_sc_pack #(.DIN_W(2), .RATIO(4), .DEPTH(4)) dut_b (
    .Clock(Clock), .Reset(b_reset), .Data(b_data), .WrEn(b_wr), .RdEn(b_rd),
    .Q(b_q), .Full(b_full), .Empty(b_empty), .AlmostFull(b_af),
    .AlmostEmpty(b_ae), .Count(b_count), .Overflow(b_ovf), .Underflow(b_udf)
  );

  // ---------------- scoreboard / model state ----------------
  logic [3:0] exp_q[$];
  logic [7:0] exp_b_q[$];
  int         n_cmp = 0;
  int         n_mis = 0;
  int         m_count;
  int         m_pc;
  logic [1:0] m_p0;
  logic       m_ovf, m_udf, m_qv;
  logic [3:0] m_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic exp_empty;
`ifdef FIFO_FWFT_EN
    exp_empty = ~m_qv;
    if (m_qv) check("q_head", {28'd0, Q}, {28'd0, exp_q[0]});
`else
    exp_empty = (m_count == 0);
    check("q", {28'd0, Q}, {28'd0, m_q});
`endif
    check("count", {27'd0, Count}, m_count);
    check("full", {31'd0, Full}, {31'd0, m_count == 16});
    check("empty", {31'd0, Empty}, {31'd0, exp_empty});
    check("almost_full", {31'd0, AlmostFull}, {31'd0, m_count >= 14});
    check("almost_empty", {31'd0, AlmostEmpty}, {31'd0, m_count <= 2});
    check("overflow", {31'd0, Overflow}, {31'd0, m_ovf});
    check("underflow", {31'd0, Underflow}, {31'd0, m_udf});
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    Reset = 1'b1; WrEn = 1'b0; RdEn = 1'b0;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    m_count = 0; m_pc = 0; m_p0 = '0; m_ovf = 1'b0; m_udf = 1'b0; m_qv = 1'b0; m_q = '0;
    exp_q.delete();
    check("rst_q", {28'd0, Q}, 32'd0);
    check("rst_count", {27'd0, Count}, 32'd0);
    check("rst_empty", {31'd0, Empty}, 32'd1);
    check("rst_ae", {31'd0, AlmostEmpty}, 32'd1);
    check("rst_full", {31'd0, Full}, 32'd0);
    check("rst_af", {31'd0, AlmostFull}, 32'd0);
    check("rst_ovf", {31'd0, Overflow}, 32'd0);
    check("rst_udf", {31'd0, Underflow}, 32'd0);
  endtask

  task automatic step(input logic wr, input logic [1:0] d, input logic rd);
    logic full, empty, wr_acc, complete, rd_acc;
    int   ram;
    WrEn = wr; Data = d; RdEn = rd;
    @(posedge Clock);
    full = (m_count == 16);
`ifdef FIFO_FWFT_EN
    empty = ~m_qv;
`else
    empty = (m_count == 0);
`endif
    ram      = m_count - (m_qv ? 1 : 0);
    wr_acc   = wr & ~full;
    complete = wr_acc & (m_pc == 1);
    rd_acc   = rd & ~empty;
    if (wr && full) m_ovf = 1'b1;
    if (rd && empty) m_udf = 1'b1;
    if (rd_acc) m_q = exp_q.pop_front();
    if (wr_acc) begin
      if (complete) begin
        exp_q.push_back({d, m_p0});
        m_pc = 0;
      end else begin
        m_p0 = d;
        m_pc = 1;
      end
    end
    m_count = m_count + (complete ? 1 : 0) - (rd_acc ? 1 : 0);
    if ((!m_qv || rd_acc) && ram > 0) m_qv = 1'b1;
    else if (rd_acc) m_qv = 1'b0;
    #1;
    WrEn = 1'b0; RdEn = 1'b0;
    check_all();
  endtask

  task automatic b_step(input logic wr, input logic [1:0] d, input logic rd);
    b_wr = wr; b_data = d; b_rd = rd;
    @(posedge Clock);
    #1;
    b_wr = 1'b0; b_rd = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    @(posedge Clock);
    #1;
    b_reset = 1'b0;
    do_reset();

    // pack 1,2,3,0 into 0x9 and 0x3, then read both
    step(1'b1, 2'd1, 1'b0);
    step(1'b1, 2'd2, 1'b0);
    step(1'b1, 2'd3, 1'b0);
    step(1'b1, 2'd0, 1'b0);
    check("tp_count2", {27'd0, Count}, 32'd2);
    step(1'b0, 2'd0, 1'b0);
    step(1'b0, 2'd0, 1'b1);
    step(1'b0, 2'd0, 1'b1);
    check("tp_last_q", {28'd0, Q}, 32'h3);
    check("tp_empty", {31'd0, Empty}, 32'd1);

    // read on empty FIFO after reset; underflow sticks
    do_reset();
    step(1'b0, 2'd0, 1'b1);
    check("udf_set", {31'd0, Underflow}, 32'd1);
    check("udf_q", {28'd0, Q}, 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 1'b0);
    check("udf_sticky", {31'd0, Underflow}, 32'd1);

    // fill to full, overflow, then simultaneous traffic at the top
    do_reset();
    for (int i = 0; i < 32; i++) step(1'b1, 2'($urandom_range(0, 3)), 1'b0);
    check("fill_full", {31'd0, Full}, 32'd1);
    check("fill_count", {27'd0, Count}, 32'd16);
    step(1'b1, 2'd3, 1'b0);
    check("fill_ovf", {31'd0, Overflow}, 32'd1);
    step(1'b1, 2'd2, 1'b1);
    check("full_rw_count", {27'd0, Count}, 32'd15);
    step(1'b1, 2'd1, 1'b1);
    check("piece_rd_count", {27'd0, Count}, 32'd14);
    for (int i = 0; i < 16; i++) step(1'b0, 2'd0, 1'b1);
    check("drain_count", {27'd0, Count}, 32'd0);

    // random mixed traffic
    do_reset();
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 99) < 60, 2'($urandom_range(0, 3)), $urandom_range(0, 99) < 45);
    for (int i = 0; i < 20; i++) step(1'b0, 2'd0, 1'b1);

    // instance B: reset mid-word must discard the stale pieces
    b_step(1'b1, 2'd3, 1'b0);
    b_step(1'b1, 2'd3, 1'b0);
    b_step(1'b1, 2'd3, 1'b0);
    check("b_partial_count", {29'd0, b_count}, 32'd0);
    b_reset = 1'b1;
    @(posedge Clock);
    #1;
    b_reset = 1'b0;
    check("b_rst_count", {29'd0, b_count}, 32'd0);
    for (int i = 0; i < 4; i++) b_step(1'b1, 2'(i), 1'b0);
    exp_b_q.push_back(8'hE4);
    check("b_count1", {29'd0, b_count}, 32'd1);
`ifdef FIFO_FWFT_EN
    b_step(1'b0, 2'd0, 1'b0);
    check("b_fwft_empty", {31'd0, b_empty}, 32'd0);
    check("b_word", {24'd0, b_q}, {24'd0, exp_b_q.pop_front()});
    b_step(1'b0, 2'd0, 1'b1);
`else
    b_step(1'b0, 2'd0, 1'b1);
    check("b_word", {24'd0, b_q}, {24'd0, exp_b_q.pop_front()});
`endif
    check("b_empty", {31'd0, b_empty}, 32'd1);
    check("b_flags", {29'd0, b_full, b_ovf, b_udf}, 32'd0);
    check("b_almost", {30'd0, b_af, b_ae}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
